// File: rtl/dmi_uart_framer.sv
// Byte framer between the UART byte streams and the DMI TAP write/read ports.
// Six MSB-first bytes carry one 41-bit request in, and one 41-bit response back out.
module dmi_uart_framer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [7:0]  RX_DATA_I,
    input  logic        RX_VALID_I,
    output logic        RX_READY_O,
    output logic [7:0]  TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_READY_I,
    output logic [40:0] TAP_WRITE_DATA_O,
    output logic        TAP_WRITE_VALID_O,
    input  logic        TAP_WRITE_READY_I,
    output logic        TAP_READ_READY_O,
    input  logic [40:0] TAP_READ_DATA_I,
    input  logic        TAP_READ_VALID_I,
    output logic        FRAME_DROP_O
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        RX_COLLECT,
        TAP_WRITE,
        TAP_READ,
        TX_SEND
    } state_t;

    state_t        state_q, state_d;
    logic [40:0]   rx_shift_q;
    logic [47:0]   tx_shift_q;
    logic [2:0]    byte_cnt_q;
    logic [IW-1:0] idle_q;
    logic          drop_q;

    logic rx_hs, tap_w_hs, tap_r_hs, tx_hs, last_byte, timeout_hit;

    assign rx_hs     = RX_VALID_I && (state_q == RX_COLLECT);
    assign tap_w_hs  = TAP_WRITE_READY_I && (state_q == TAP_WRITE);
    assign tap_r_hs  = TAP_READ_VALID_I && (state_q == TAP_READ);
    assign tx_hs     = TX_READY_I && (state_q == TX_SEND);
    assign last_byte = (byte_cnt_q == 3'd5);
    // An RX byte in the same cycle as the timeout wins and keeps the frame alive.
    assign timeout_hit = (state_q == RX_COLLECT) && (byte_cnt_q != 3'd0) && !RX_VALID_I
                         && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_I) begin
        if (RST_I) state_q <= RX_COLLECT;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets its default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_COLLECT: if (rx_hs && last_byte) state_d = TAP_WRITE;
            TAP_WRITE:  if (tap_w_hs) state_d = (rx_shift_q[1:0] == 2'b01) ? TAP_READ : RX_COLLECT;
            TAP_READ:   if (tap_r_hs) state_d = TX_SEND;
            TX_SEND:    if (tx_hs && last_byte) state_d = RX_COLLECT;
            default:    state_d = RX_COLLECT;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= timeout_hit;
            case (state_q)
                RX_COLLECT: begin
                    if (rx_hs) begin
                        // Bits above 40 simply fall off the top, discarding the pad bits.
                        rx_shift_q <= {rx_shift_q[32:0], RX_DATA_I};
                        byte_cnt_q <= last_byte ? 3'd0 : byte_cnt_q + 3'd1;
                        idle_q     <= '0;
                    end else if (byte_cnt_q != 3'd0) begin
                        if (timeout_hit) begin
                            byte_cnt_q <= '0;
                            idle_q     <= '0;
                        end else begin
                            idle_q <= idle_q + IW'(1);
                        end
                    end
                end
                TAP_READ: begin
                    if (tap_r_hs) tx_shift_q <= {7'b0, TAP_READ_DATA_I};
                end
                TX_SEND: begin
                    if (tx_hs) begin
                        tx_shift_q <= {tx_shift_q[39:0], 8'h00};
                        byte_cnt_q <= last_byte ? 3'd0 : byte_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RX_READY_O        = (state_q == RX_COLLECT);
    assign TAP_WRITE_VALID_O = (state_q == TAP_WRITE);
    assign TAP_READ_READY_O  = (state_q == TAP_READ);
    assign TX_VALID_O        = (state_q == TX_SEND);
    assign TAP_WRITE_DATA_O  = rx_shift_q;
    assign TX_DATA_O         = tx_shift_q[47:40];
    assign FRAME_DROP_O      = drop_q;

endmodule

// File: tb/tb_dmi_uart_framer.sv
// Scoreboard bench for dmi_uart_framer: expected TAP requests and TX bytes are queued
// as stimulus is driven and compared when the DUT hands them over.
module tb_dmi_uart_framer;

    localparam int TO = 16;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic [7:0]  RX_DATA_I = '0;
    logic        RX_VALID_I = 1'b0;
    logic        RX_READY_O;
    logic [7:0]  TX_DATA_O;
    logic        TX_VALID_O;
    logic        TX_READY_I = 1'b0;
    logic [40:0] TAP_WRITE_DATA_O;
    logic        TAP_WRITE_VALID_O;
    logic        TAP_WRITE_READY_I = 1'b0;
    logic        TAP_READ_READY_O;
    logic [40:0] TAP_READ_DATA_I = '0;
    logic        TAP_READ_VALID_I = 1'b0;
    logic        FRAME_DROP_O;

    dmi_uart_framer #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .RX_DATA_I(RX_DATA_I), .RX_VALID_I(RX_VALID_I), .RX_READY_O(RX_READY_O),
        .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I),
        .TAP_WRITE_DATA_O(TAP_WRITE_DATA_O), .TAP_WRITE_VALID_O(TAP_WRITE_VALID_O),
        .TAP_WRITE_READY_I(TAP_WRITE_READY_I), .TAP_READ_READY_O(TAP_READ_READY_O),
        .TAP_READ_DATA_I(TAP_READ_DATA_I), .TAP_READ_VALID_I(TAP_READ_VALID_I),
        .FRAME_DROP_O(FRAME_DROP_O)
    );

    always #5 CLK_I = ~CLK_I;

    int          n_vec = 0;
    int          n_err = 0;
    int          drop_cnt = 0;
    logic [40:0] tap_q[$];
    logic [7:0]  tx_q[$];
    logic        tapw_stall = 1'b0, tx_stall = 1'b0;
    logic [40:0] tapw_prev = '0;
    logic [7:0]  tx_prev = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; inputs only change just after the rising edge.
    always @(negedge CLK_I) begin
        if (RST_I) begin
            tapw_stall <= 1'b0;
            tx_stall   <= 1'b0;
        end else begin
            if (FRAME_DROP_O) drop_cnt <= drop_cnt + 1;
            if (tapw_stall) begin
                check("tapw_hold_valid", TAP_WRITE_VALID_O, 1);
                check("tapw_hold_data", TAP_WRITE_DATA_O, tapw_prev);
                check("rx_ready_tapw_stall", RX_READY_O, 0);
            end
            if (tx_stall) begin
                check("tx_hold_valid", TX_VALID_O, 1);
                check("tx_hold_data", TX_DATA_O, tx_prev);
                check("rx_ready_tx_stall", RX_READY_O, 0);
            end
            if (TAP_WRITE_VALID_O && TAP_WRITE_READY_I) begin
                check("tap_pending", tap_q.size() != 0, 1);
                if (tap_q.size() != 0) check("tap_data", TAP_WRITE_DATA_O, tap_q.pop_front());
            end
            if (TX_VALID_O && TX_READY_I) begin
                check("tx_pending", tx_q.size() != 0, 1);
                if (tx_q.size() != 0) check("tx_byte", TX_DATA_O, tx_q.pop_front());
            end
            tapw_stall <= TAP_WRITE_VALID_O && !TAP_WRITE_READY_I;
            tapw_prev  <= TAP_WRITE_DATA_O;
            tx_stall   <= TX_VALID_O && !TX_READY_I;
            tx_prev    <= TX_DATA_O;
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return RX_READY_O;
            1:       return TAP_WRITE_VALID_O;
            2:       return TAP_READ_READY_O;
            default: return TX_VALID_O;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wait_sig(input int sel, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sig(sel)) return;
            step();
        end
        check(tag, sig(sel), 1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        RX_DATA_I  = b;
        RX_VALID_I = 1'b1;
        wait_sig(0, "wait_rx_ready");
        step();
        RX_VALID_I = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] w);
        tap_q.push_back(w[40:0]);
        for (int i = 0; i < 6; i++) rx_byte(w[47 - 8 * i -: 8]);
        check("tapw_latency", TAP_WRITE_VALID_O, 1);
    endtask

    task automatic tap_write(input int stall, input logic is_read);
        TAP_WRITE_READY_I = 1'b0;
        wait_sig(1, "wait_tapw_valid");
        repeat (stall) step();
        TAP_WRITE_READY_I = 1'b1;
        step();
        TAP_WRITE_READY_I = 1'b0;
        check("rd_ready_latency", TAP_READ_READY_O, is_read);
        check("rx_ready_latency", RX_READY_O, !is_read);
    endtask

    task automatic respond(input logic [40:0] resp);
        logic [47:0] w;
        w = {7'b0, resp};
        wait_sig(2, "wait_tap_read_ready");
        TAP_READ_DATA_I  = resp;
        TAP_READ_VALID_I = 1'b1;
        for (int i = 0; i < 6; i++) tx_q.push_back(w[47 - 8 * i -: 8]);
        step();
        TAP_READ_VALID_I = 1'b0;
        check("tx_latency", TX_VALID_O, 1);
    endtask

    task automatic recv_tx(input logic toggle);
        int  cnt;
        logic hs;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 6; i++) begin
            TX_READY_I = toggle ? ~i[0] : 1'b1;
            hs = TX_VALID_O && TX_READY_I;
            step();
            if (hs) cnt++;
        end
        TX_READY_I = 1'b0;
        check("tx_count", cnt, 6);
        check("tx_done_valid", TX_VALID_O, 0);
        check("tx_done_rx_ready", RX_READY_O, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_ready", RX_READY_O, 1);
        check("rst_tx_valid", TX_VALID_O, 0);
        check("rst_tx_data", TX_DATA_O, 0);
        check("rst_tapw_valid", TAP_WRITE_VALID_O, 0);
        check("rst_tapw_data", TAP_WRITE_DATA_O, 0);
        check("rst_tap_read_ready", TAP_READ_READY_O, 0);
        check("rst_drop", FRAME_DROP_O, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [47:0] w;
        logic [40:0] resp;

        RST_I = 1'b1;
        repeat (3) step();
        check_reset_outputs();
        RST_I = 1'b0;

        // Plain read
        send_frame(48'h00_44_00_00_00_01);
        tap_write(0, 1'b1);
        respond(41'h3_7AB6_FBBC);
        recv_tx(1'b0);

        // Write: no read request, no TX
        send_frame(48'h00_40_00_00_00_06);
        tap_write(0, 1'b0);
        repeat (4) step();
        check("write_no_read", TAP_READ_READY_O, 0);
        check("write_no_tx", TX_VALID_O, 0);

        // Pad bits in the first byte are ignored
        send_frame(48'hFE_44_00_00_00_01);
        tap_write(0, 1'b1);
        respond(41'h1_2345_6789);
        recv_tx(1'b1);

        // Timeout on a partial frame, then a full read frame
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'h33);
        d0 = drop_cnt;
        repeat (TO - 1) step();
        check("drop_early", drop_cnt, d0);
        repeat (5) step();
        check("drop_once", drop_cnt, d0 + 1);
        check("drop_rx_ready", RX_READY_O, 1);
        send_frame(48'h00_8A_00_00_00_01);
        tap_write(0, 1'b1);
        respond(41'h0_0BAD_F00D);
        recv_tx(1'b0);

        // Backpressure on the TAP write and the TX side
        send_frame(48'h00_44_00_00_00_01);
        tap_write(5, 1'b1);
        respond(41'h3_7AB6_FBBC);
        recv_tx(1'b1);

        // Random frames with all op codes
        for (int k = 0; k < 6; k++) begin
            w = {$urandom, $urandom_range(0, 65535)};
            w[1:0] = 2'(k % 4);
            send_frame(w);
            tap_write(k % 3, w[1:0] == 2'b01);
            if (w[1:0] == 2'b01) begin
                resp = {$urandom_range(0, 511), $urandom};
                respond(resp);
                recv_tx(k[1]);
            end
        end

        // Reset in the middle of a TX frame
        send_frame(48'h00_44_00_00_00_01);
        tap_write(0, 1'b1);
        respond(41'h3_7AB6_FBBC);
        TX_READY_I = 1'b1;
        step();
        step();
        TX_READY_I = 1'b0;
        RST_I = 1'b1;
        step();
        check_reset_outputs();
        RST_I = 1'b0;
        check("tx_left_at_reset", tx_q.size(), 4);
        tx_q.delete();
        send_frame(48'h00_46_00_00_00_01);
        tap_write(0, 1'b1);
        respond(41'h1_FFFF_FFFC);
        recv_tx(1'b0);

        repeat (3) step();
        check("tap_q_empty", tap_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
